// File: rtl/elastic_buffer.sv
// Two-entry valid/ready elastic buffer (head + skid) that registers a mux output stream.
// Optional zero-latency bypass when empty: define CGRA_EB_FALLTHROUGH_EN.
module elastic_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] skid;
  logic                  accept;
  logic                  emit;

  // Ready depends only on registered state and rst, which breaks the backward ready path.
  assign data_in_ready = (state != FULL) && !rst;

`ifdef CGRA_EB_FALLTHROUGH_EN
  assign data_out_valid = (state != EMPTY) || (data_in_valid && !rst);
  assign data_out       = (state != EMPTY) ? head : (rst ? '0 : data_in);
`else
  assign data_out_valid = (state != EMPTY);
  assign data_out       = head;
`endif

  assign accept = data_in_valid && data_in_ready;
  assign emit   = data_out_valid && data_out_ready;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush) begin
      // A same-cycle emit already completed downstream; an accepted word is dropped.
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
`ifdef CGRA_EB_FALLTHROUGH_EN
          if (accept && !emit) begin
            head  <= data_in;
            state <= ONE;
          end
`else
          if (accept) begin
            head  <= data_in;
            state <= ONE;
          end
`endif
        end
        ONE: begin
          if (accept && emit) begin
            head <= data_in;
          end else if (accept) begin
            skid  <= data_in;
            state <= FULL;
          end else if (emit) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            head  <= skid;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_elastic_buffer.sv
// Self-checking bench for elastic_buffer: directed test-plan sequences plus random traffic
// compared every cycle against a queue-based FIFO model (honours CGRA_EB_FALLTHROUGH_EN).
module tb_elastic_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready;

  int tests  = 0;
  int failed = 0;

  logic [31:0] q[$];     // words the buffer must be holding, oldest first
  logic [31:0] seen[$];  // words observed leaving the buffer
  bit          model_ok  = 0;
  bit          zero_head = 0;

  elastic_buffer #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !rst && (q.size() < 2);
  endfunction

  function automatic bit exp_valid();
`ifdef CGRA_EB_FALLTHROUGH_EN
    return (q.size() > 0) || (data_in_valid && !rst);
`else
    return q.size() > 0;
`endif
  endfunction

  function automatic logic [31:0] exp_data();
    if (q.size() > 0) return q[0];
`ifdef CGRA_EB_FALLTHROUGH_EN
    return rst ? 32'h0 : data_in;
`else
    return 32'h0;
`endif
  endfunction

  // Compare process: outputs checked mid-cycle against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      check("ready", {31'b0, data_in_ready}, {31'b0, exp_ready()});
      check("valid", {31'b0, data_out_valid}, {31'b0, exp_valid()});
      if (exp_valid()) begin
        check("data", data_out, exp_data());
      end else begin
`ifndef CGRA_EB_FALLTHROUGH_EN
        if (zero_head) check("data_zero", data_out, 32'h0);
`endif
      end
      if (data_out_valid && data_out_ready) seen.push_back(data_out);
    end
  end

  // Model update on the edge, using the inputs presented during the cycle.
  always @(posedge clk) begin
    bit acc, emt;
    if (rst) begin
      q.delete();
      zero_head = 1;
      model_ok  = 1;
    end else if (model_ok) begin
      acc = data_in_valid && exp_ready();
      emt = exp_valid() && data_out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (acc) q.push_back(data_in);
        if (emt) void'(q.pop_front());
        if (acc) zero_head = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_seen(input string name, input logic [31:0] exp[$]);
    check({name, "_count"}, seen.size(), exp.size());
    foreach (exp[i]) begin
      if (i < seen.size()) check(name, seen[i], exp[i]);
    end
  endtask

  initial begin
    logic [31:0] exp_words[$];

    // Reset held 3 cycles with a word offered.
    rst = 1; flush = 0; data_in_valid = 1; data_in = 32'hFF; data_out_ready = 1;
    repeat (3) cyc();
    check("rst_ready", {31'b0, data_in_ready}, 32'h0);
    check("rst_valid", {31'b0, data_out_valid}, 32'h0);
    check("rst_data", data_out, 32'h0);
    rst = 0; data_in_valid = 0; data_in = 0;
    cyc();
    check("post_rst_ready", {31'b0, data_in_ready}, 32'h1);
    check("post_rst_valid", {31'b0, data_out_valid}, 32'h0);

    // Streaming 1..16 with downstream always ready.
    seen.delete();
    for (int i = 1; i <= 16; i++) begin
      data_in_valid = 1; data_in = i;
`ifdef CGRA_EB_FALLTHROUGH_EN
      if (i == 1) check("ft_latency0", data_out, 32'h1);
`endif
      cyc();
`ifndef CGRA_EB_FALLTHROUGH_EN
      if (i == 1) check("latency1", data_out, 32'h1);
`endif
    end
    data_in_valid = 0;
    repeat (2) cyc();
    exp_words.delete();
    for (int i = 1; i <= 16; i++) exp_words.push_back(i);
    check_seen("stream", exp_words);

    // Backpressure: A, B held, C stalled.
    seen.delete();
    data_out_ready = 0; data_in_valid = 1; data_in = 32'hA;
    cyc();
    data_in = 32'hB;
    cyc();
    check("bp_ready_low", {31'b0, data_in_ready}, 32'h0);
    check("bp_head", data_out, 32'hA);
    data_in = 32'hC;
    cyc();
    check("bp_hold", data_out, 32'hA);
    data_out_ready = 1;
    repeat (2) cyc();
    data_in_valid = 0;
    repeat (2) cyc();
    exp_words = '{32'hA, 32'hB, 32'hC};
    check_seen("bp", exp_words);

    // Simultaneous accept and emit in ONE.
    data_out_ready = 0; data_in_valid = 1; data_in = 32'h5;
    cyc();
    data_in = 32'h6; data_out_ready = 1;
    cyc();
    check("simul_data", data_out, 32'h6);
    check("simul_valid", {31'b0, data_out_valid}, 32'h1);
    data_in_valid = 0;
    cyc();

    // Flush a FULL buffer.
    data_out_ready = 0; data_in_valid = 1; data_in = 32'h1;
    cyc();
    data_in = 32'h2;
    cyc();
    check("fl_full", {31'b0, data_in_ready}, 32'h0);
    data_in_valid = 0; flush = 1;
    cyc();
    flush = 0;
    check("fl_valid", {31'b0, data_out_valid}, 32'h0);
    check("fl_ready", {31'b0, data_in_ready}, 32'h1);
    data_in_valid = 1; data_in = 32'h3;
    cyc();
    data_in_valid = 0; data_out_ready = 1;
    check("fl_next", data_out, 32'h3);
    cyc();

    // Reset while FULL.
    data_out_ready = 0; data_in_valid = 1; data_in = 32'h7;
    cyc();
    data_in = 32'h8;
    cyc();
    data_in_valid = 0; data_in = 0; rst = 1;
    cyc();
    rst = 0;
    check("mid_rst_valid", {31'b0, data_out_valid}, 32'h0);
    check("mid_rst_data", data_out, 32'h0);
    data_in_valid = 1; data_in = 32'h9; data_out_ready = 1;
    cyc();
    data_in_valid = 0;
`ifndef CGRA_EB_FALLTHROUGH_EN
    check("resume", data_out, 32'h9);
`endif
    cyc();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      data_in_valid  = ($urandom_range(99) < 70);
      data_in        = $urandom;
      data_out_ready = ($urandom_range(99) < 65);
      flush          = ($urandom_range(99) < 3);
      rst            = ($urandom_range(199) < 1);
      cyc();
    end
    rst = 0; flush = 0; data_in_valid = 0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
